// File: rtl/mac_seq_acc.sv
// Sequential radix-2 shift-add multiplier feeding a running accumulator.
// Optional macro MAC_SATURATE_EN: clamp the accumulator on overflow instead of wrapping.
module mac_seq_acc #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   acc_clr,
    input  logic [WIDTH-1:0]       data_a,
    input  logic [WIDTH-1:0]       data_b,
    output logic                   busy,
    output logic                   done,
    output logic [2*WIDTH-1:0]     product,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   overflow,
    output logic [2:0]             state
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_ACC  = 3'd2,
        S_DONE = 3'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [2*WIDTH-1:0]     pp_q, pp_d;
    logic [2*WIDTH-1:0]     product_q, product_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   ov_q, ov_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [ACC_WIDTH:0]     prod_ext_s;
    logic [ACC_WIDTH-1:0]   acc_base_s;
    logic [ACC_WIDTH:0]     sum_s;
    logic                   carry_s;

    // Accumulator adder; acc_clr on the ACC edge means clear-then-add.
    always_comb begin
        prod_ext_s                = '0;
        prod_ext_s[2*WIDTH-1:0]   = product_q;
        if (acc_clr) begin
            acc_base_s = '0;
        end else begin
            acc_base_s = acc_q;
        end
        sum_s   = {1'b0, acc_base_s} + prod_ext_s;
        carry_s = sum_s[ACC_WIDTH];
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        pp_d      = pp_q;
        product_d = product_q;
        acc_d     = acc_q;
        ov_d      = ov_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d              = '0;
                    mcand_d[WIDTH-1:0]   = data_a;
                    mplier_d             = data_b;
                    cnt_d                = '0;
                    pp_d                 = '0;
                    state_d              = S_MUL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                pp_d     = pp_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    product_d = pp_d;
                    state_d   = S_ACC;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_ACC: begin
`ifdef MAC_SATURATE_EN
                if (carry_s) begin
                    acc_d = '1;
                end else begin
                    acc_d = sum_s[ACC_WIDTH-1:0];
                end
`else
                acc_d = sum_s[ACC_WIDTH-1:0];
`endif
                ov_d    = (acc_clr ? 1'b0 : ov_q) | carry_s;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clear outside the ACC edge leaves the FSM alone.
        if (acc_clr && (state_q != S_ACC)) begin
            acc_d = '0;
            ov_d  = 1'b0;
        end else begin
            acc_d = acc_d;
        end

        busy_d = (state_d == S_MUL) || (state_d == S_ACC) || (state_d == S_DONE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            pp_q      <= '0;
            product_q <= '0;
            acc_q     <= '0;
            ov_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            pp_q      <= pp_d;
            product_q <= product_d;
            acc_q     <= acc_d;
            ov_q      <= ov_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign product  = product_q;
    assign acc_out  = acc_q;
    assign overflow = ov_q;
    assign state    = state_q;

endmodule

// File: tb/tb_mac_seq_acc.sv
// Self-checking bench for mac_seq_acc (WIDTH=8, ACC_WIDTH=16): table vectors,
// random operations against an arithmetic model, and hand-written corner sequences.
module tb_mac_seq_acc;

    localparam int W  = 8;
    localparam int AW = 16;
    localparam longint MAXV = (longint'(1) << AW) - 1;
`ifdef MAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic          acc_clr;
    logic [W-1:0]  data_a;
    logic [W-1:0]  data_b;
    logic          busy;
    logic          done;
    logic [2*W-1:0] product;
    logic [AW-1:0] acc_out;
    logic          overflow;
    logic [2:0]    state;

    int checks   = 0;
    int failures = 0;

    longint acc_m  = 0;
    bit     ov_m   = 1'b0;
    longint prod_m = 0;

    mac_seq_acc #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .acc_clr(acc_clr),
        .data_a(data_a), .data_b(data_b), .busy(busy), .done(done),
        .product(product), .acc_out(acc_out), .overflow(overflow), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_state"}, state, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_product"}, product, 0);
        chk({name, "_acc"}, acc_out, 0);
        chk({name, "_ovf"}, overflow, 0);
    endtask

    task automatic model_add(input longint p, input bit clr);
        longint s;
        if (clr) begin
            s    = p;
            ov_m = 1'b0;
        end else begin
            s = acc_m + p;
        end
        if (s > MAXV) begin
            ov_m  = 1'b1;
            acc_m = SAT ? MAXV : (s % (MAXV + 1));
        end else begin
            acc_m = s;
        end
    endtask

    // One operation: start in IDLE, optional disturbance and acc_clr on the ACC edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit disturb, input bit clr_acc_edge, input string name);
        longint p;
        int j;
        bit found;
        p = longint'(a) * longint'(b);
        @(negedge clk);
        data_a = a;
        data_b = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, "_state_mul"}, state, 1);
        chk({name, "_busy_mul"}, busy, 1);
        found = 1'b0;
        j = 0;
        for (int i = 1; i <= 40; i++) begin
            if (disturb && i < W) begin
                data_a = W'($urandom);
                data_b = W'($urandom);
                start  = 1'b1;
            end
            if (clr_acc_edge && i == W + 1) acc_clr = 1'b1;
            @(posedge clk);
            #1;
            start   = 1'b0;
            acc_clr = 1'b0;
            if (i == W - 1) begin
                chk({name, "_prod_hold"}, product, prod_m);
                chk({name, "_state_still_mul"}, state, 1);
            end
            if (i == W) begin
                chk({name, "_prod_at_acc"}, product, p);
                chk({name, "_state_acc"}, state, 2);
            end
            if (done) begin
                found = 1'b1;
                j = i;
                break;
            end
        end
        prod_m = p;
        model_add(p, clr_acc_edge);
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: done not seen within 40 cycles", name);
        end else begin
            chk({name, "_latency"}, j, W + 1);
            chk({name, "_state_done"}, state, 3);
            chk({name, "_busy_done"}, busy, 1);
            chk({name, "_product"}, product, p);
            chk({name, "_acc"}, acc_out, acc_m);
            chk({name, "_ovf"}, overflow, ov_m);
        end
        if (disturb) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, "_done_pulse"}, done, 0);
        chk({name, "_state_idle"}, state, 0);
        chk({name, "_busy_idle"}, busy, 0);
    endtask

    task automatic clear_acc(input string name);
        @(negedge clk);
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        acc_m = 0;
        ov_m  = 1'b0;
        chk({name, "_acc"}, acc_out, 0);
        chk({name, "_ovf"}, overflow, 0);
        chk({name, "_state"}, state, 0);
    endtask

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [2*W-1:0] exp_prod;
        logic [AW-1:0] exp_acc;
        logic          exp_ov;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{a: 8'd17,  b: 8'd5,   exp_prod: 16'd85,  exp_acc: 16'd85,  exp_ov: 1'b0};
        vecs[1] = '{a: 8'd11,  b: 8'd12,  exp_prod: 16'd132, exp_acc: 16'd217, exp_ov: 1'b0};
        vecs[2] = '{a: 8'd14,  b: 8'd9,   exp_prod: 16'd126, exp_acc: 16'd343, exp_ov: 1'b0};
        vecs[3] = '{a: 8'd0,   b: 8'd200, exp_prod: 16'd0,   exp_acc: 16'd343, exp_ov: 1'b0};
        vecs[4] = '{a: 8'd255, b: 8'd1,   exp_prod: 16'd255, exp_acc: 16'd598, exp_ov: 1'b0};

        rst     = 1'b0;
        start   = 1'b0;
        acc_clr = 1'b0;
        data_a  = '0;
        data_b  = '0;
        @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 5; v++) begin
            run_op(vecs[v].a, vecs[v].b, 1'b0, 1'b0, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_tbl_prod", v), product, vecs[v].exp_prod);
            chk($sformatf("vec%0d_tbl_acc", v), acc_out, vecs[v].exp_acc);
            chk($sformatf("vec%0d_tbl_ovf", v), overflow, vecs[v].exp_ov);
        end

        run_op(8'd201, 8'd77, 1'b1, 1'b0, "disturb");

        clear_acc("clr_idle");
        run_op(8'd10, 8'd10, 1'b0, 1'b0, "pre100");
        chk("acc_is_100", acc_out, 100);
        run_op(8'd3, 8'd4, 1'b0, 1'b1, "clr_at_acc");
        chk("clr_at_acc_tbl", acc_out, 12);

        clear_acc("clr_pre_ovf");
        run_op(8'd255, 8'd255, 1'b0, 1'b0, "ovf_fill");
        chk("ovf_fill_tbl", acc_out, 65025);
        run_op(8'd255, 8'd255, 1'b0, 1'b0, "ovf_hit");
        chk("ovf_hit_tbl_acc", acc_out, SAT ? 65535 : 64514);
        chk("ovf_hit_tbl_ovf", overflow, 1);
        run_op(8'd1, 8'd1, 1'b0, 1'b0, "ovf_sticky");
        chk("ovf_sticky_tbl", overflow, 1);
        clear_acc("clr_post_ovf");

        for (int r = 0; r < 25; r++) begin
            run_op(W'($urandom), W'($urandom), ($urandom % 4) == 0, ($urandom % 8) == 0,
                   $sformatf("rnd%0d", r));
        end

        // Reset during the fourth MUL cycle aborts the operation.
        @(negedge clk);
        data_a = 8'd7;
        data_b = 8'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_abort_state", state, 1);
        #1;
        rst = 1'b0;
        #1;
        chk_zero_outputs("abort");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        acc_m  = 0;
        ov_m   = 1'b0;
        prod_m = 0;
        run_op(8'd2, 8'd3, 1'b0, 1'b0, "post_abort");
        chk("post_abort_tbl", acc_out, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
